ahblite_uart_tx: RTL and testbench
==================================

# ahblite_uart_tx

AHB-lite slave UART transmitter for the Cortex-M0 SoC, attached to a free interconnect port (HSEL/HADDR/HTRANS... of one P-port) and driving an 8N1 serial line. The CPU writes bytes into a FIFO. A baud-rate counter and frame state machine serialise those bytes onto TXD. Status and baud divisor are software-visible registers.

## Interface
- FIFO_DEPTH, 8: TX FIFO entries; power of two, 2..64.
- BAUD_RESET, 16'd433: reset value of BAUDDIV (50 MHz / 115200 − 1).
- HCLK  in  1  system clock; every register uses this clock.
- HRESETn  in  1  asynchronous, active-low reset.
- HSEL, HADDR[31:0], HTRANS[1:0], HSIZE[2:0], HPROT[3:0], HWRITE, HWDATA[31:0], HREADY  in  standard AHB-lite slave inputs.
- HRDATA  out  32  read data.
- HREADYOUT  out  1  constant 1; the slave has no wait states.
- HRESP  out  1  constant 0 (OKAY).
- TXD  out  1  serial output, idle high.
- TX_IRQ  out  1  present only with UART_TX_IRQ_EN; see Configuration.

## Operation
- Address phase is captured when HSEL & HTRANS[1] & HREADY. The design registers HADDR[3:2] and HWRITE. Register access happens in the following data phase, using HWDATA from that cycle.
- Register map, decoded from HADDR[3:2]:
  - 0x0 DATA (W): HWDATA[7:0] is pushed into the FIFO. Reads return 0.
  - 0x4 STATUS (R):
    - [0] busy: FSM not IDLE.
    - [1] full.
    - [2] empty.
    - [3] overflow: sticky. Cleared by a STATUS read.
    - [15:8] FIFO count.
  - 0x8 BAUDDIV (R/W): bits [15:0]. Bit period = BAUDDIV+1 HCLK cycles.
  - 0xC CTRL (R/W): [0] irq_en. The register exists only with the macro; otherwise it reads 0 and ignores writes.
- Writes to read-only registers are ignored.
- FIFO overflow: a DATA write while full (evaluated before the edge) is dropped and sets overflow. This holds even if a pop happens on the same edge.
- FSM states: IDLE → START → DATA → STOP → IDLE.
  - IDLE: if the FIFO is not empty, pop a byte, load the shift register, latch BAUDDIV into the bit-period counter, drive TXD=0 and go to START.
  - START: one bit period, then go to DATA.
  - DATA: 8 bits, LSB first; TXD = shift[0]. Shift at each bit boundary.
  - STOP: TXD=1 for one bit period, then go to IDLE.
- A BAUDDIV write takes effect from the next frame's START; a frame in flight is unaffected.
- Reset values:
  - TXD=1, HRDATA=0, FIFO empty.
  - State IDLE, overflow=0, BAUDDIV=BAUD_RESET, irq_en=0, TX_IRQ=0.
- Reset mid-frame: TXD returns high asynchronously and FIFO contents are discarded.

## Timing
- A DATA write whose data phase completes at edge N reaches the FIFO at edge N. In an idle design, TXD falls at edge N+1.
- Frame length is exactly 10×(BAUDDIV+1) cycles from TXD falling to the end of the stop bit.
- Back-to-back frames have exactly 1 HCLK of IDLE between the stop bit end and the next start bit.
- STATUS reflects state after the previous edge. A read in the data phase immediately following a DATA write already shows the incremented count.
- TXD is driven from a flop; there is no combinational path from the bus.

## Configuration
- UART_TX_IRQ_EN defined:
  - Adds the CTRL register and the TX_IRQ port.
  - TX_IRQ is registered: it equals irq_en & empty & ~busy, with 1-cycle latency.
- Not defined:
  - No TX_IRQ port.
  - CTRL address reads 0.
  - No interrupt logic is synthesised.

## Structure
- Package uart_pkg holds:
  - register offset localparams (DATA/STATUS/BAUDDIV/CTRL);
  - the FSM state typedef (IDLE/START/DATA/STOP);
  - STATUS bit indices;
  - the default BAUD_RESET.
- Sub-module uart_tx_fifo: a synchronous FIFO.
  - Parameter DEPTH; ports push, wdata, pop, rdata, full, empty, count.
  - Read data is valid in the same cycle as the pop (first-word fall-through).

## Test plan
- Reset check: reset, then read STATUS → 0x0000_0004. Read BAUDDIV → 433. TXD must be 1.
- Single frame: BAUDDIV=3, then write DATA 0xA5. TXD falls 1 cycle after the write edge. Then 10 bits of 4 cycles each: 0,1,0,1,0,0,1,0,1,1. Busy clears after 40 cycles.
- Back-to-back frames: BAUDDIV=1, write 0x00 then 0xFF. Frames are 20 cycles each, separated by exactly 1 idle-high cycle. Count reads 1 right after the second write.
- Overflow: with FIFO_DEPTH=8 and BAUDDIV=100, write 10 bytes.
  - STATUS shows full=1, overflow=1, count=8 (9th byte popped then 10th dropped if timing allows; check against model).
  - A second STATUS read shows overflow=0.
- Mid-frame changes: change BAUDDIV mid-frame, then assert HRESETn low mid-frame.
  - The current frame keeps the old period.
  - Reset forces TXD=1 and STATUS=0x0000_0004 immediately.
- IRQ (UART_TX_IRQ_EN only): write CTRL=1 while idle → TX_IRQ=1 one cycle later. Write DATA → TX_IRQ drops until the stop bit of the last byte ends.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared register map, FSM states and STATUS layout for the AHB-lite UART transmitter
package uart_pkg;

    localparam logic [1:0] REG_DATA    = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_BAUDDIV = 2'd2;
    localparam logic [1:0] REG_CTRL    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_e;

    localparam int STAT_BUSY      = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_EMPTY     = 2;
    localparam int STAT_OVF       = 3;
    localparam int STAT_COUNT_LSB = 8;

    localparam logic [15:0] BAUD_RESET_DEFAULT = 16'd433;

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - first-word fall-through byte FIFO; pushes while full and pops while empty are ignored
module uart_tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [7:0]               wdata,
    input  logic                     pop,
    output logic [7:0]               rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Storage carries no reset; clearing the pointers is enough to discard contents.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/ahblite_uart_tx.sv
// rtl/ahblite_uart_tx.sv - AHB-lite slave 8N1 UART transmitter; define UART_TX_IRQ_EN for CTRL register and TX_IRQ
module ahblite_uart_tx
    import uart_pkg::*;
#(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] BAUD_RESET = BAUD_RESET_DEFAULT
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic [3:0]  HPROT,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
`ifdef UART_TX_IRQ_EN
    output logic        TX_IRQ,
`endif
    output logic        TXD
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic        dphase_q;
    logic        dwrite_q;
    logic [1:0]  daddr_q;
    logic        wr_en;
    logic        rd_en;

    logic [15:0] baud_q;
    logic        ovf_q;

    tx_state_e   state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] div_q, div_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_q, bit_d;
    logic        txd_q, txd_d;
    logic        busy;

    logic          fifo_push;
    logic          fifo_pop;
    logic [7:0]    fifo_rdata;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    logic unused_bus;

    assign HREADYOUT  = 1'b1;
    assign HRESP      = 1'b0;
    assign TXD        = txd_q;
    assign unused_bus = ^{HADDR[31:4], HADDR[1:0], HTRANS[0], HSIZE, HPROT, HWDATA[31:16]};

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dphase_q <= 1'b0;
            dwrite_q <= 1'b0;
            daddr_q  <= '0;
        end else if (HREADY) begin
            dphase_q <= HSEL & HTRANS[1];
            dwrite_q <= HWRITE;
            daddr_q  <= HADDR[3:2];
        end
    end

    assign wr_en     = dphase_q & dwrite_q;
    assign rd_en     = dphase_q & ~dwrite_q;
    assign fifo_push = wr_en & (daddr_q == REG_DATA);
    assign busy      = (state_q != ST_IDLE);

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (HCLK),
        .rst_n (HRESETn),
        .push  (fifo_push),
        .wdata (HWDATA[7:0]),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Overflow looks at full before the edge, so a same-edge pop never rescues the byte.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            baud_q <= BAUD_RESET;
            ovf_q  <= 1'b0;
        end else begin
            if (wr_en && daddr_q == REG_BAUDDIV) begin
                baud_q <= HWDATA[15:0];
            end
            if (fifo_push && fifo_full) begin
                ovf_q <= 1'b1;
            end else if (rd_en && daddr_q == REG_STATUS) begin
                ovf_q <= 1'b0;
            end
        end
    end

`ifdef UART_TX_IRQ_EN
    logic irq_en_q;
    logic irq_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (wr_en && daddr_q == REG_CTRL) begin
                irq_en_q <= HWDATA[0];
            end
            irq_q <= irq_en_q & fifo_empty & ~busy;
        end
    end

    assign TX_IRQ = irq_q;
`endif

    always_comb begin
        HRDATA = '0;
        if (rd_en) begin
            case (daddr_q)
                REG_STATUS: begin
                    HRDATA[STAT_BUSY]                = busy;
                    HRDATA[STAT_FULL]                = fifo_full;
                    HRDATA[STAT_EMPTY]               = fifo_empty;
                    HRDATA[STAT_OVF]                 = ovf_q;
                    HRDATA[STAT_COUNT_LSB +: 8]      = 8'(fifo_count);
                end
                REG_BAUDDIV: HRDATA[15:0] = baud_q;
`ifdef UART_TX_IRQ_EN
                REG_CTRL:    HRDATA[0]    = irq_en_q;
`endif
                default:     HRDATA       = '0;
            endcase
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            shift_q <= '0;
            bit_q   <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            txd_q   <= txd_d;
        end
    end

    // div_q holds the divisor latched at frame start so BAUDDIV writes only affect later frames.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        shift_d  = shift_q;
        bit_d    = bit_q;
        txd_d    = txd_q;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                txd_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rdata;
                    div_d    = baud_q;
                    cnt_d    = baud_q;
                    txd_d    = 1'b0;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q == '0) begin
                    cnt_d   = div_q;
                    txd_d   = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_DATA: begin
                if (cnt_q == '0) begin
                    cnt_d = div_q;
                    if (bit_q == 3'd7) begin
                        txd_d   = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        txd_d   = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_STOP: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ahblite_uart_tx.sv
// tb/tb_ahblite_uart_tx.sv - directed/random bench for ahblite_uart_tx against a frame-timeline reference model
module tb_ahblite_uart_tx;

    localparam int DEPTH = 8;
    localparam int HIST  = 32768;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        HSEL = 1'b0;
    logic [31:0] HADDR = '0;
    logic [1:0]  HTRANS = 2'b00;
    logic [2:0]  HSIZE = 3'b010;
    logic [3:0]  HPROT = 4'b0011;
    logic        HWRITE = 1'b0;
    logic [31:0] HWDATA = '0;
    logic        HREADY = 1'b1;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic        TXD;
`ifdef UART_TX_IRQ_EN
    logic        TX_IRQ;
    logic        irq_hist [HIST];
`endif

    always #5 HCLK = ~HCLK;

    ahblite_uart_tx #(
        .FIFO_DEPTH (DEPTH),
        .BAUD_RESET (16'd433)
    ) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HSIZE     (HSIZE),
        .HPROT     (HPROT),
        .HWRITE    (HWRITE),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HRDATA    (HRDATA),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
`ifdef UART_TX_IRQ_EN
        .TX_IRQ    (TX_IRQ),
`endif
        .TXD       (TXD)
    );

    // One TXD sample per cycle, taken half a cycle after each rising edge.
    int   cyc = 0;
    logic txd_hist [HIST];

    always @(negedge HCLK) begin
        if (cyc < HIST) begin
            txd_hist[cyc] <= TXD;
`ifdef UART_TX_IRQ_EN
            irq_hist[cyc] <= TX_IRQ;
`endif
        end
        cyc <= cyc + 1;
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: a byte queue plus a list of frames with their start sample and divisor.
    typedef struct {
        int         s;
        logic [7:0] b;
        int         div;
    } frame_t;

    frame_t     frames[$];
    logic [7:0] mq[$];
    int         mready[$];
    int         next_free = 0;
    int         mdiv = 433;
    bit         movf = 1'b0;
    int         checked = 0;

    task automatic model_advance(input int t);
        frame_t f;
        int     s;
        while (mq.size() > 0) begin
            s = (mready[0] > next_free) ? mready[0] : next_free;
            if (s > t) break;
            f.s   = s;
            f.b   = mq[0];
            f.div = mdiv;
            frames.push_back(f);
            next_free = s + 10 * (mdiv + 1) + 1;
            void'(mq.pop_front());
            void'(mready.pop_front());
        end
    endtask

    task automatic model_push(input int w, input logic [7:0] b);
        model_advance(w - 1);
        if (mq.size() == DEPTH) begin
            movf = 1'b1;
        end else begin
            mq.push_back(b);
            mready.push_back(w + 1);
        end
    endtask

    task automatic model_status(input int r, output logic [31:0] st);
        frame_t f;
        bit     busy;
        model_advance(r);
        busy = 1'b0;
        if (frames.size() > 0) begin
            f = frames[frames.size() - 1];
            busy = (r >= f.s) && (r < f.s + 10 * (f.div + 1));
        end
        st = {16'h0, 8'(mq.size()), 4'h0, movf, (mq.size() == 0), (mq.size() == DEPTH), busy};
    endtask

    task automatic model_reset();
        mq.delete();
        mready.delete();
        frames.delete();
        next_free = 0;
        mdiv = 433;
        movf = 1'b0;
        checked = 0;
    endtask

    task automatic ahb_write(input logic [3:0] addr, input logic [31:0] data, output int w);
        @(negedge HCLK); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {28'h0, addr};
        @(negedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = data;
        @(posedge HCLK);
        w = cyc;
    endtask

    task automatic ahb_read(input logic [3:0] addr, output logic [31:0] data, output int r);
        @(negedge HCLK); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = {28'h0, addr};
        @(negedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        data = HRDATA;
        r = cyc - 1;
        @(posedge HCLK);
    endtask

    task automatic write_data(input logic [7:0] b);
        int w;
        ahb_write(4'h0, {24'h0, b}, w);
        model_push(w, b);
    endtask

    task automatic write_baud(input int div);
        int w;
        ahb_write(4'h8, div, w);
        model_advance(w);
        mdiv = div;
    endtask

    task automatic check_status(input string tag);
        logic [31:0] obs, exp;
        int r;
        ahb_read(4'h4, obs, r);
        model_status(r, exp);
        check(tag, obs, exp);
        movf = 1'b0;
    endtask

    task automatic wait_frames_done();
        frame_t f;
        int     last, guard;
        model_advance(32'h3fff_ffff);
        if (frames.size() == 0) return;
        f = frames[frames.size() - 1];
        last = f.s + 10 * (f.div + 1) + 2;
        guard = 0;
        while (cyc <= last && guard < 20000) begin
            @(negedge HCLK);
            guard++;
        end
        check("wait_bound", (cyc > last), 1);
    endtask

    task automatic check_frames();
        frame_t f;
        int     len, bad, first, bitn;
        logic   e;
        for (int i = checked; i < frames.size(); i++) begin
            f = frames[i];
            len = 10 * (f.div + 1);
            bad = 0;
            first = -1;
            if (txd_hist[f.s - 1] !== 1'b1) begin
                bad++;
                first = -1;
            end
            for (int k = 0; k < len; k++) begin
                bitn = k / (f.div + 1);
                e = (bitn == 0) ? 1'b0 : (bitn == 9) ? 1'b1 : f.b[bitn - 1];
                if (txd_hist[f.s + k] !== e) begin
                    if (first < 0) first = k;
                    bad++;
                end
            end
            check($sformatf("frame%0d_b%02h_div%0d_firstbad%0d", i, f.b, f.div, first), bad, 0);
        end
        checked = frames.size();
    endtask

    initial begin
        logic [31:0] rd;
        int          r, w, n;

        // Reset state
        repeat (3) @(negedge HCLK);
        #1;
        check("reset_txd", TXD, 1);
        check("reset_hrdata", HRDATA, 0);
        check("hreadyout", HREADYOUT, 1);
        check("hresp", HRESP, 0);
        HRESETn = 1'b1;
        check_status("reset_status");
        ahb_read(4'h4, rd, r);
        check("reset_status_literal", rd, 32'h0000_0004);
        ahb_read(4'h8, rd, r);
        check("reset_bauddiv", rd, 433);
        ahb_read(4'hC, rd, r);
        check("reset_ctrl", rd, 0);

        // Single frames: 0xA5 at divisor 3, then random bytes and divisors including 0
        write_baud(3);
        write_data(8'hA5);
        check_status("single_busy");
        wait_frames_done();
        check_frames();
        check_status("single_idle");
        for (int i = 0; i < 3; i++) begin
            n = (i == 0) ? 0 : int'($urandom_range(1, 6));
            write_baud(n);
            ahb_read(4'h8, rd, r);
            check("bauddiv_rb", rd, n);
            write_data(8'($urandom));
            wait_frames_done();
            check_frames();
        end
        ahb_read(4'h0, rd, r);
        check("data_reads_zero", rd, 0);

        // Back-to-back frames
        write_baud(1);
        write_data(8'h00);
        write_data(8'hFF);
        check_status("b2b_count");
        wait_frames_done();
        check_frames();
        for (int i = 0; i < 2; i++) begin
            write_baud(int'($urandom_range(0, 2)));
            for (int j = 0; j < 3; j++) write_data(8'($urandom));
            check_status("b2b_rand_status");
            wait_frames_done();
            check_frames();
        end

        // Overflow
        write_baud(100);
        for (int i = 0; i < 10; i++) write_data(8'($urandom));
        check_status("ovf_status1");
        check_status("ovf_status2");
        ahb_write(4'h4, 32'hFFFF_FFFF, w);
        check_status("status_write_ignored");
        wait_frames_done();
        check_frames();
        check_status("ovf_drained");

`ifdef UART_TX_IRQ_EN
        // Interrupt
        ahb_write(4'hC, 32'h1, w);
        repeat (3) @(negedge HCLK);
        check("irq_before", irq_hist[w], 0);
        check("irq_after", irq_hist[w + 1], 1);
        ahb_read(4'hC, rd, r);
        check("ctrl_rb", rd, 1);
        write_baud(2);
        ahb_write(4'h0, 32'h0000_003C, w);
        model_push(w, 8'h3C);
        wait_frames_done();
        check_frames();
        begin
            frame_t f;
            int len;
            f = frames[frames.size() - 1];
            len = 10 * (f.div + 1);
            check("irq_hold_at_push", irq_hist[w], 1);
            check("irq_drop", irq_hist[w + 1], 0);
            check("irq_mid_stop", irq_hist[f.s + len - 1], 0);
            check("irq_stop_end", irq_hist[f.s + len], 0);
            check("irq_rise", irq_hist[f.s + len + 1], 1);
        end
`endif

        // BAUDDIV change mid-frame only affects the following frame
        write_baud(5);
        write_data(8'($urandom));
        write_data(8'($urandom));
        repeat (20) @(negedge HCLK);
        write_baud(2);
        ahb_read(4'h8, rd, r);
        check("mid_bauddiv_rb", rd, 2);
        wait_frames_done();
        check_frames();

        // Asynchronous reset mid-frame
        write_baud(7);
        write_data(8'h00);
        repeat (12) @(negedge HCLK);
        #2;
        check("pre_reset_txd_low", TXD, 0);
        HRESETn = 1'b0;
        #1;
        check("reset_async_txd", TXD, 1);
        check("reset_async_hrdata", HRDATA, 0);
        model_reset();
        repeat (2) @(negedge HCLK);
        #1;
        HRESETn = 1'b1;
        check_status("post_reset_status");
        ahb_read(4'hC, rd, r);
        check("post_reset_ctrl", rd, 0);
        ahb_read(4'h8, rd, r);
        check("post_reset_bauddiv", rd, 433);
        write_baud(int'($urandom_range(0, 4)));
        write_data(8'($urandom));
        wait_frames_done();
        check_frames();
        check_status("final_status");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
